// File: rtl/mem_write_logger_if.sv
// Bus between the pipeline/debug-unit side and the memory write logger.
// The master side drives the EX/MEM latch, stall and drain handshake; the slave side is the logger.
interface mem_write_logger_if #(
  parameter int unsigned NB_EX_MEM = 76,
  parameter int unsigned NB_ADDR   = 5,
  parameter int unsigned NB_CNT    = 6
);
  logic                 i_stop;
  logic [NB_EX_MEM-1:0] i_EX_MEM;
  logic                 i_dump_start;
  logic                 i_rd_next;
  logic                 o_rd_valid;
  logic [NB_ADDR-1:0]   o_rd_addr;
  logic                 o_rd_last;
  logic [NB_CNT-1:0]    o_count;
  logic                 o_done;

  modport master (
    output i_stop, i_EX_MEM, i_dump_start, i_rd_next,
    input  o_rd_valid, o_rd_addr, o_rd_last, o_count, o_done
  );

  modport slave (
    input  i_stop, i_EX_MEM, i_dump_start, i_rd_next,
    output o_rd_valid, o_rd_addr, o_rd_last, o_count, o_done
  );
endinterface

// File: rtl/mem_write_logger.sv
// Records each distinct data-memory word address stored by EX/MEM in first-write order,
// then hands the list to the debug unit one address per handshake after halt.
module mem_write_logger #(
  parameter int unsigned NB_EX_MEM = 76,
  parameter int unsigned NB_ADDR   = 5,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NB_CNT    = 6
) (
  input  logic              i_clk,
  input  logic              o_reset_pipeline,
  mem_write_logger_if.slave io_bus
);

  localparam logic [1:0] S_LOG   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned ALU_LSB       = 7;
  localparam int unsigned MEM_WRITE_BIT = 3;
  localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

  logic [1:0]         r_state,    w_state_next;
  logic [DEPTH-1:0]   r_seen,     w_seen_next;
  logic [NB_CNT-1:0]  r_wr_ptr,   w_wr_ptr_next;
  logic [NB_CNT-1:0]  r_rd_ptr,   w_rd_ptr_next;
  logic               r_rd_valid, w_rd_valid_next;
  logic               r_rd_last,  w_rd_last_next;
  logic               r_done,     w_done_next;
  logic [NB_ADDR-1:0] r_rd_addr,  w_rd_addr_next;
  logic [NB_ADDR-1:0] r_log [DEPTH];

  logic [NB_ADDR-1:0] w_addr;
  logic [NB_ADDR-1:0] w_head;
  logic [NB_CNT-1:0]  w_rd_ptr_inc;
  logic               w_log_en;
  logic               w_pop;
  logic               w_unused_ex_mem;

  // Word address only: byte offset and access size are irrelevant to which word was touched.
  assign w_addr   = io_bus.i_EX_MEM[ALU_LSB+2 +: NB_ADDR];
  assign w_log_en = (r_state == S_LOG) && io_bus.i_EX_MEM[MEM_WRITE_BIT] &&
                    !io_bus.i_stop && !r_seen[w_addr];
  assign w_pop        = (r_state == S_DRAIN) && r_rd_valid && io_bus.i_rd_next;
  assign w_rd_ptr_inc = r_rd_ptr + CNT_ONE;
  // An empty log with a same-cycle write means that write becomes entry 0.
  assign w_head = (r_wr_ptr == '0) ? w_addr : r_log[0];

  assign w_unused_ex_mem = ^{io_bus.i_EX_MEM[NB_EX_MEM-1:ALU_LSB+NB_ADDR+2],
                             io_bus.i_EX_MEM[ALU_LSB+1:MEM_WRITE_BIT+1],
                             io_bus.i_EX_MEM[MEM_WRITE_BIT-1:0]};

  always_comb begin
    w_state_next    = r_state;
    w_seen_next     = r_seen;
    w_wr_ptr_next   = r_wr_ptr;
    w_rd_ptr_next   = r_rd_ptr;
    w_rd_valid_next = r_rd_valid;
    w_rd_last_next  = r_rd_last;
    w_done_next     = r_done;
    w_rd_addr_next  = r_rd_addr;
    case (r_state)
      S_LOG: begin
        if (w_log_en) begin
          w_seen_next[w_addr] = 1'b1;
          w_wr_ptr_next       = r_wr_ptr + CNT_ONE;
        end
        if (io_bus.i_dump_start) begin
          if (w_wr_ptr_next == '0) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next    = S_DRAIN;
            w_rd_valid_next = 1'b1;
            w_rd_ptr_next   = '0;
            w_rd_addr_next  = w_head;
            w_rd_last_next  = (w_wr_ptr_next == CNT_ONE);
          end
        end
      end
      S_DRAIN: begin
        if (w_pop) begin
          if (r_rd_last) begin
            w_state_next    = S_DONE;
            w_rd_valid_next = 1'b0;
            w_rd_last_next  = 1'b0;
            w_done_next     = 1'b1;
          end else begin
            w_rd_ptr_next  = w_rd_ptr_inc;
            w_rd_addr_next = r_log[w_rd_ptr_inc[NB_ADDR-1:0]];
            w_rd_last_next = (w_rd_ptr_inc == (r_wr_ptr - CNT_ONE));
          end
        end
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_LOG;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge o_reset_pipeline) begin
    if (o_reset_pipeline) begin
      r_state    <= S_LOG;
      r_seen     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_seen     <= w_seen_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_rd_valid <= w_rd_valid_next;
      r_rd_last  <= w_rd_last_next;
      r_done     <= w_done_next;
      r_rd_addr  <= w_rd_addr_next;
    end
  end

  // Storage needs no reset: only entries below the write pointer are ever read.
  always_ff @(posedge i_clk) begin
    if (w_log_en) begin
      r_log[r_wr_ptr[NB_ADDR-1:0]] <= w_addr;
    end
  end

  assign io_bus.o_rd_valid = r_rd_valid;
  assign io_bus.o_rd_addr  = r_rd_addr;
  assign io_bus.o_rd_last  = r_rd_last;
  assign io_bus.o_count    = r_wr_ptr;
  assign io_bus.o_done     = r_done;

endmodule

// File: tb/tb_mem_write_logger.sv
// Randomized scoreboard bench for mem_write_logger: a list-of-unique-words model feeds an
// expected-address queue that a negedge monitor pops on every drain handshake.
module tb_mem_write_logger;

  localparam int P_LOG   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_DONE  = 2;

  logic clk;
  logic rst;

  mem_write_logger_if #(.NB_EX_MEM(76), .NB_ADDR(5), .NB_CNT(6)) bus ();

  mem_write_logger #(
    .NB_EX_MEM(76),
    .NB_ADDR  (5),
    .DEPTH    (32),
    .NB_CNT   (6)
  ) dut (
    .i_clk           (clk),
    .o_reset_pipeline(rst),
    .io_bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: unique word addresses in first-write order, plus drain phase.
  int phase;
  bit seen [32];
  int log_q [$];
  int exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [75:0] mk_ex(input bit st, input logic [31:0] alu);
    logic [75:0] v;
    v       = {12'($urandom), $urandom, $urandom};
    v[38:7] = alu;
    v[3]    = st;
    return v;
  endfunction

  task automatic model_clear();
    phase = P_LOG;
    foreach (seen[i]) seen[i] = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  // Inputs are applied 1 time unit after a posedge; the model steps at the following posedge.
  task automatic cyc(input bit st, input logic [31:0] alu, input bit stop, input bit dump,
                     input bit nxt);
    int w;
    bus.i_EX_MEM     = mk_ex(st, alu);
    bus.i_stop       = stop;
    bus.i_dump_start = dump;
    bus.i_rd_next    = nxt;
    @(posedge clk);
    if (phase == P_LOG) begin
      if (st && !stop) begin
        w = int'((alu >> 2) % 32);
        if (!seen[w]) begin
          seen[w] = 1'b1;
          log_q.push_back(w);
        end
      end
      if (dump) begin
        if (log_q.size() == 0) phase = P_DONE;
        else begin
          phase = P_DRAIN;
          exp_q = log_q;
        end
      end
    end else if (phase == P_DRAIN && exp_q.size() == 0) begin
      phase = P_DONE;
    end
    #1;
    check("count", 32'(bus.o_count), 32'(log_q.size()));
    check("done", 32'(bus.o_done), 32'(phase == P_DONE));
    if (phase != P_DRAIN) check("valid_idle", 32'(bus.o_rd_valid), 32'd0);
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 400 && phase != P_DONE; i++) begin
      if (rnd) cyc($urandom % 2, $urandom, 1'b0, ($urandom % 4) == 0, $urandom % 2);
      else     cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    if (phase != P_DONE) check("drain_timeout", 32'd0, 32'd1);
    // Done is sticky: further dump pulses and stores change nothing.
    cyc(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.o_rd_valid), 32'd0);
    check("rst_addr", 32'(bus.o_rd_addr), 32'd0);
    check("rst_last", 32'(bus.o_rd_last), 32'd0);
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    model_clear();
    bus.i_EX_MEM     = '0;
    bus.i_stop       = 1'b0;
    bus.i_dump_start = 1'b0;
    bus.i_rd_next    = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_rd_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        check("rd_addr", 32'(bus.o_rd_addr), 32'(exp_q[0]));
        check("rd_last", 32'(bus.o_rd_last), 32'(exp_q.size() == 1));
        if (bus.i_rd_next) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.i_EX_MEM     = '0;
    bus.i_stop       = 1'b0;
    bus.i_dump_start = 1'b0;
    bus.i_rd_next    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_mid();

    // 1: three consecutive word stores drain as 3, 4, 5.
    cyc(1'b1, 32'h0F, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h13, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h17, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain(1'b0);

    // 2: mixed-size stores inside one word collapse to a single entry.
    reset_mid();
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h23, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain(1'b0);

    // 3: stalled store is not logged; empty dump goes straight to done.
    reset_mid();
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain(1'b0);

    // 4: store coincident with dump is included; store during drain is not.
    reset_mid();
    cyc(1'b1, 32'h04, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h08, 1'b0, 1'b0, 1'b0);
    drain(1'b0);

    // 5: asynchronous reset mid-drain, then a fresh single-entry run.
    reset_mid();
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset_mid();
    cyc(1'b1, 32'h0C, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain(1'b0);

    // 6: full capacity plus a repeat, drained with random consumer gaps.
    reset_mid();
    for (int i = 0; i < 32; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain(1'b1);

    // 7: random traffic, stalls and access sizes.
    for (int r = 0; r < 3; r++) begin
      reset_mid();
      repeat (40) cyc($urandom % 2, $urandom, ($urandom % 4) == 0, 1'b0, $urandom % 2);
      cyc($urandom % 2, $urandom, 1'b0, 1'b1, 1'b0);
      drain(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_logger.md
Name: mem_write_logger

Overview:
- Pipeline-side responder to the UART debug unit.
- While the program runs, it records every distinct data-memory word address written by the EX/MEM stage.
- After halt, the debug unit drains the list one address per handshake. It feeds each address back into its data-memory read port, so only touched memory is dumped over UART.
- The block is cleared whenever the debug unit resets the pipeline.

Parameters:
- NB_EX_MEM, 76, width of the EX/MEM latch bus.
- NB_ADDR, 5, data-memory word-address width; equals width of the debug unit's data-mem read address.
- DEPTH, 32, log capacity; must equal 2**NB_ADDR.
- NB_CNT, 6, entry-count width, clog2(DEPTH)+1.

Ports:
- i_clk  input  1  pipeline clock.
- o_reset_pipeline  input  1  asynchronous, active-high reset; driven by the debug unit's o_reset_pipeline.
- i_stop  input  1  pipeline stalled; no logging while high.
- i_EX_MEM  input  NB_EX_MEM  EX/MEM latch. Bit map [75:0] = {write_reg[4:0], store_data[31:0], ALU_result[31:0], WB_write, WB_mem_to_reg, MEM_read, MEM_write, MEM_unsigned, MEM_byte_half_word[1:0]}. MEM_write = bit 3; ALU_result = bits [38:7].
- i_dump_start  input  1  single-cycle pulse; begin drain.
- i_rd_next  input  1  consumer accepts the current o_rd_addr.
- o_rd_valid  output  1  o_rd_addr holds a valid entry.
- o_rd_addr  output  NB_ADDR  word address at the log head.
- o_rd_last  output  1  current entry is the final one.
- o_count  output  NB_CNT  number of logged entries.
- o_done  output  1  drain complete.

Behaviour:
- Reset (async, while o_reset_pipeline high):
  - o_rd_valid=0, o_rd_addr=0, o_rd_last=0, o_count=0, o_done=0.
  - Seen-bitmap, write pointer and read pointer all cleared.
  - State = S_LOG.
  - Reset mid-drain discards all entries; no further o_rd_valid.
- Word address: ALU_result[NB_ADDR+1:2]. The byte offset and MEM_byte_half_word are ignored, so byte, half and word stores all log the containing word.
- S_LOG, logging condition: MEM_write=1 && i_stop=0 at a posedge.
  - If the seen bit for the word address is clear: set it, store the address at the write pointer, increment the write pointer and o_count (registered, 1-cycle latency).
  - If the seen bit is already set: no change, so no duplicate entries.
  - Entries are kept in first-write order.
- Overflow: impossible, since DEPTH = 2**NB_ADDR and entries are unique. The count saturates at DEPTH by construction.
- S_LOG on i_dump_start:
  - A write qualifying in the same cycle is logged first and is included in the drain.
  - If o_count (including that write) = 0: go to S_DONE, o_done=1 next cycle, o_rd_valid never asserted.
  - Otherwise go to S_DRAIN. o_rd_valid=1 and o_rd_addr = entry 0 on the next cycle.
- S_DRAIN:
  - Writes are ignored, even with MEM_write=1.
  - o_rd_addr = entry[read pointer]; o_rd_last = (read pointer == o_count-1).
  - i_rd_next with o_rd_valid=1: advance the read pointer. The next entry is presented the following cycle.
  - i_rd_next on the last entry: o_rd_valid=0 and state = S_DONE next cycle.
  - i_rd_next while o_rd_valid=0 is ignored.
  - i_rd_next held high pops one entry per cycle.
  - i_dump_start during S_DRAIN is ignored.
- S_DONE:
  - o_done=1, o_rd_valid=0.
  - Stays in S_DONE until reset; i_dump_start is ignored.
  - o_count keeps its value for readback.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset then, with i_stop=0, stores to ALU_result 0x0F, 0x13, 0x17 on consecutive cycles; pulse i_dump_start; assert i_rd_next each cycle -> o_count=3; o_rd_addr sequence 3, 4, 5; o_rd_last high only with 5; o_done=1 one cycle after the third pop.
2. Stores to 0x20, 0x22, 0x23, 0x20 (byte/half sizes mixed) -> o_count=1; single drained entry 8 with o_rd_last=1.
3. Store to 0x40 with i_stop=1, then i_dump_start -> no entry; o_count=0; o_done=1 next cycle; o_rd_valid stays 0.
4. i_dump_start in the same cycle as a store to 0x04 -> o_count=1; drains entry 1. A store to 0x08 during S_DRAIN is not logged.
5. Log 4 addresses, pop 2, then pulse o_reset_pipeline asynchronously mid-cycle -> all outputs 0 immediately. A new store to 0x0C then drains as the single entry 3.
6. Stores to all 32 word addresses (0x00..0x7C) plus a repeat of 0x00 -> o_count=32; drain yields 0..31 in order; o_rd_last on 31; o_rd_valid gaps honoured when i_rd_next is held low.
